// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front-end key conditioner.
//   EDGE_*      : edge-selection codes for the EDGE_MODE parameter
//   rpt_state_e : per-channel auto-repeat state encoding
//   max2        : elaboration-time helper for counter sizing
package calc_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_WAIT   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: synchroniser, debouncer, edge detector and auto-repeat FSM.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   key_in : raw asynchronous key level, 1 = pressed
//   level  : debounced key level
//   pulse  : one-cycle event strobe (edge or auto-repeat)
//   rpt    : high with pulse when that pulse is an auto-repeat
//
// state      | meaning
// RPT_IDLE   | key released or repeat disabled; waiting for an accepted press
// RPT_WAIT   | key held; counting the initial repeat delay
// RPT_REPEAT | key held; emitting a repeat pulse every REPEAT_RATE cycles
module key_channel
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DB_CYCLES    = 16,
  parameter int EDGE_MODE    = 0,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic level,
  output logic pulse,
  output logic rpt
);

  localparam int CNT_W  = $clog2(DB_CYCLES + 1);
  localparam int RC_MAX = max2(REPEAT_DELAY, REPEAT_RATE);
  localparam int RC_W   = (RC_MAX < 1) ? 1 : $clog2(RC_MAX + 1);

  // Repeat logic is pointless when only releases are reported.
  localparam bit RPT_EN = (REPEAT_DELAY != 0) && (EDGE_MODE != EDGE_FALL);

  localparam int RD_LAST_I = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int RR_LAST_I = (REPEAT_RATE  > 0) ? REPEAT_RATE  - 1 : 0;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [RC_W-1:0]  RD_LAST = RC_W'(RD_LAST_I);
  localparam logic [RC_W-1:0]  RR_LAST = RC_W'(RR_LAST_I);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, rpt_q;
  rpt_state_e             state_q;
  logic [RC_W-1:0]        rc_q;

  logic s;
  logic rise, fall;
  logic edge_pulse;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], key_in};
  assign s      = sync_q[SYNC_STAGES-1];

  // The level flips on the cycle the counter would reach DB_CYCLES, so the
  // counter itself only ever holds 0..DB_CYCLES-1.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (s != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = s;
        rise    = s;
        fall    = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    edge_pulse = 1'b0;
    if (EDGE_MODE == EDGE_RISE) begin
      edge_pulse = rise;
    end else if (EDGE_MODE == EDGE_FALL) begin
      edge_pulse = fall;
    end else begin
      edge_pulse = rise | fall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rpt_q   <= 1'b0;
      state_q <= RPT_IDLE;
      rc_q    <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= edge_pulse;
      rpt_q   <= 1'b0;

      // A release always wins over a repeat due on the same cycle.
      if (!RPT_EN || fall) begin
        state_q <= RPT_IDLE;
        rc_q    <= '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            if (rise) begin
              state_q <= RPT_WAIT;
              rc_q    <= '0;
            end
          end
          RPT_WAIT: begin
            if (rc_q == RD_LAST) begin
              pulse_q <= 1'b1;
              rpt_q   <= 1'b1;
              rc_q    <= '0;
              state_q <= RPT_REPEAT;
            end else begin
              rc_q <= rc_q + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (rc_q == RR_LAST) begin
              pulse_q <= 1'b1;
              rpt_q   <= 1'b1;
              rc_q    <= '0;
            end else begin
              rc_q <= rc_q + 1'b1;
            end
          end
          default: begin
            state_q <= RPT_IDLE;
            rc_q    <= '0;
          end
        endcase
      end
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;
  assign rpt   = rpt_q;

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel keypad input conditioner. Each raw key input is synchronised,
// debounced, edge-detected and optionally auto-repeated; channels are
// fully independent.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   in    : raw asynchronous key levels, 1 = pressed
//   level : debounced key levels
//   pulse : one-cycle event strobes per channel
//   rpt   : marks pulses that are auto-repeats
module key_conditioner #(
  parameter int CH           = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DB_CYCLES    = 16,
  parameter int EDGE_MODE    = 0,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] level,
  output logic [CH-1:0] pulse,
  output logic [CH-1:0] rpt
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    key_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .EDGE_MODE    (EDGE_MODE),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .key_in (in[g]),
      .level  (level[g]),
      .pulse  (pulse[g]),
      .rpt    (rpt[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: three instances (rising, both-edge,
// falling) share clk/rst/in; expectations are hand-computed per cycle k,
// where k counts rising edges after the inputs of a phase were applied.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_v;

  logic [1:0] lv_r, p_r, r_r;
  logic [1:0] lv_b, p_b, r_b;
  logic [1:0] lv_f, p_f, r_f;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_conditioner #(.CH(2), .SYNC_STAGES(2), .DB_CYCLES(4), .EDGE_MODE(0),
                    .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut_rise (
    .clk(clk), .rst(rst), .in(in_v), .level(lv_r), .pulse(p_r), .rpt(r_r));

  key_conditioner #(.CH(2), .SYNC_STAGES(2), .DB_CYCLES(4), .EDGE_MODE(2),
                    .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut_both (
    .clk(clk), .rst(rst), .in(in_v), .level(lv_b), .pulse(p_b), .rpt(r_b));

  key_conditioner #(.CH(2), .SYNC_STAGES(2), .DB_CYCLES(4), .EDGE_MODE(1),
                    .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut_fall (
    .clk(clk), .rst(rst), .in(in_v), .level(lv_f), .pulse(p_f), .rpt(r_f));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed{level,rpt,pulse}=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // lv: expected level (all instances); pr/rr: rising-mode pulse/rpt;
  // pb/rb: both-mode pulse/rpt; pf: falling-mode pulse (rpt always 0).
  task automatic chk3(input string tag, input int k, input logic [1:0] lv,
                      input logic [1:0] pr, input logic [1:0] rr,
                      input logic [1:0] pb, input logic [1:0] rb,
                      input logic [1:0] pf);
    chk({tag, "/rise"}, k, {lv_r, r_r, p_r}, {lv, rr, pr});
    chk({tag, "/both"}, k, {lv_b, r_b, p_b}, {lv, rb, pb});
    chk({tag, "/fall"}, k, {lv_f, r_f, p_f}, {lv, 2'b00, pf});
  endtask

  initial begin
    logic [1:0] lv, pr, rr, pb, rb, pf;

    // Reset and idle
    rst  = 1'b1;
    in_v = 2'b00;
    tick(); tick(); tick();
    chk3("reset", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk3("idle", k, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Press ch0 and hold: press at 6, repeats at 16,19,22,25; release
    // applied after 22, level falls at 28 (repeat due at 28 suppressed).
    in_v = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      tick();
      lv = (k >= 6 && k < 28) ? 2'b01 : 2'b00;
      pr = {1'b0, (k inside {6, 16, 19, 22, 25})};
      rr = {1'b0, (k inside {16, 19, 22, 25})};
      pb = {1'b0, (k inside {6, 16, 19, 22, 25, 28})};
      rb = {1'b0, (k inside {16, 19, 22, 25})};
      pf = {1'b0, (k == 28)};
      chk3("hold", k, lv, pr, rr, pb, rb, pf);
      if (k == 22) in_v = 2'b00;
    end

    // Glitch of 3 cycles: rejected
    in_v = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk3("glitch3", k, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      if (k == 3) in_v = 2'b00;
    end

    // 4-cycle press: accepted at 6, release accepted at 10
    in_v = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      lv = (k >= 6 && k < 10) ? 2'b01 : 2'b00;
      pr = {1'b0, (k == 6)};
      pb = {1'b0, (k == 6 || k == 10)};
      pf = {1'b0, (k == 10)};
      chk3("short4", k, lv, pr, 2'b00, pb, 2'b00, pf);
      if (k == 4) in_v = 2'b00;
    end

    // Both channels together: simultaneous pulses
    in_v = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      tick();
      lv = (k >= 6 && k < 12) ? 2'b11 : 2'b00;
      pr = (k == 6) ? 2'b11 : 2'b00;
      pb = (k == 6 || k == 12) ? 2'b11 : 2'b00;
      pf = (k == 12) ? 2'b11 : 2'b00;
      chk3("dual", k, lv, pr, 2'b00, pb, 2'b00, pf);
      if (k == 6) in_v = 2'b00;
    end

    // Reset mid-debounce (edge 3) and mid-repeat (edge 21) with key held
    in_v = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      tick();
      lv = ((k >= 9 && k < 21) || (k >= 27 && k < 36)) ? 2'b01 : 2'b00;
      pr = {1'b0, (k inside {9, 19, 27})};
      rr = {1'b0, (k == 19)};
      pb = {1'b0, (k inside {9, 19, 27, 36})};
      rb = {1'b0, (k == 19)};
      pf = {1'b0, (k == 36)};
      chk3("rstmid", k, lv, pr, rr, pb, rb, pf);
      if (k == 2)  rst = 1'b1;
      if (k == 3)  rst = 1'b0;
      if (k == 20) rst = 1'b1;
      if (k == 21) rst = 1'b0;
      if (k == 30) in_v = 2'b00;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Multi-channel keypad input conditioner for the calculator front end, the generalised successor of the single-bit rising-edge detector. Each of `CH` raw key inputs is synchronised, debounced, edge-detected in a selectable mode, and optionally auto-repeated while held. It sits between the board key pins and the calculator input FSM, which consumes only the single-cycle `pulse` outputs.

## Interface
- `CH`, 4: number of independent key channels (≥1)
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2)
- `DB_CYCLES`, 16: consecutive stable synchronised cycles required to accept a level change (≥1)
- `EDGE_MODE`, 0: 0 = rising, 1 = falling, 2 = both edges produce `pulse`
- `REPEAT_DELAY`, 0: cycles from accepted press to first repeat pulse; 0 disables auto-repeat
- `REPEAT_RATE`, 8: cycles between subsequent repeat pulses (≥1)
- `clk` in 1: single system clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `in` in CH: raw asynchronous key levels, 1 = pressed
- `level` out CH: debounced key level
- `pulse` out CH: one-cycle event strobe per channel
- `rpt` out CH: high together with `pulse` when that pulse is an auto-repeat

## Operation
- Channels fully independent; identical logic per channel.
- Sync chain: `SYNC_STAGES` flops; output `s`.
- Debounce: counter `cnt` (width clog2(DB_CYCLES+1)). If `s == level`, `cnt` ← 0. Otherwise `cnt` increments; on the cycle `cnt` would reach `DB_CYCLES`, `level` ← `s` and `cnt` ← 0.
- Glitch shorter than `DB_CYCLES` synchronised cycles never changes `level`; any return to old value restarts the count.
- Edge: `pulse` asserted for exactly the cycle in which `level` changes, filtered by `EDGE_MODE`; `rpt` = 0 for edge pulses.
- Repeat FSM per channel (active only if `REPEAT_DELAY` ≠ 0 and `EDGE_MODE` ≠ 1): states IDLE, WAIT, REPEAT.
  - IDLE → WAIT on accepted rising edge; repeat counter `rc` ← 0.
  - WAIT: `rc` increments; when `rc` reaches `REPEAT_DELAY`-1, emit `pulse`=`rpt`=1, `rc` ← 0, → REPEAT.
  - REPEAT: `rc` increments; when `rc` reaches `REPEAT_RATE`-1, emit `pulse`=`rpt`=1, `rc` ← 0.
  - Any accepted falling edge → IDLE from any state, `rc` ← 0; no repeat pulse that cycle (falling edge pulse in mode 2 has `rpt`=0).
- `rc` width clog2(max(REPEAT_DELAY, REPEAT_RATE)+1); never wraps in use.

## Timing
- Reset values: sync flops 0, `cnt` 0, `rc` 0, FSM IDLE, `level` 0, `pulse` 0, `rpt` 0.
- Latency: `in` change sampled at edge t0 and held stable → `level` and `pulse` change at t0 + `SYNC_STAGES` + `DB_CYCLES`.
- First repeat pulse `REPEAT_DELAY` cycles after the press pulse; then every `REPEAT_RATE` cycles.
- `pulse` never high two consecutive cycles unless `REPEAT_RATE` = 1.
- `rst` mid-debounce or mid-repeat: all state cleared next edge; in-flight changes discarded. Key held through reset release is a fresh press after full latency.
- Simultaneous events on different channels produce simultaneous independent pulses.

## Structure
- Shared package `calc_pkg`: `EDGE_RISE`=0, `EDGE_FALL`=1, `EDGE_BOTH`=2 constants and repeat FSM state typedef.
- Sub-module `key_channel`: one channel (sync, debounce, edge, repeat FSM); top generates `CH` instances and concatenates outputs.

## Test plan
Config CH=2, SYNC_STAGES=2, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, EDGE_MODE=0 unless stated.
- Reset with `in`=2'b00, release, hold 20 cycles -> `level`, `pulse`, `rpt` all 0.
- `in[0]` 0→1 at t0, held -> `level[0]`=1 and `pulse[0]`=1 at t0+6 only; `in[1]` stays quiet.
- `in[0]` high 3 cycles then low -> `level[0]` stays 0, no pulse; high 4 cycles -> accepted.
- Hold `in[0]` after press at P -> `pulse[0]`=`rpt[0]`=1 at P+10, P+13, P+16; release -> no further pulses, FSM IDLE.
- EDGE_MODE=2: press then release -> two pulses, both `rpt`=0; EDGE_MODE=1 -> only release pulse, no repeats.
- Assert `rst` at cycle 2 of debounce and at P+12 of repeat -> outputs 0 next cycle, no pulse until full 6-cycle relatency after release.
